// File: rtl/aes_cmd_sequencer_if.sv
// aes_cmd_sequencer_if: instruction, DMA command, engine and status signals of the AES job sequencer
interface aes_cmd_sequencer_if #(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2
);
  logic [3*ADDRW+OPCODEW-1:0] instr;
  logic                       instr_valid;
  logic                       instr_ready;
  logic                       dma_valid;
  logic                       dma_ready;
  logic [ADDRW-1:0]           dma_addr;
  logic                       dma_dir;
  logic                       dma_sel;
  logic                       dma_done;
  logic                       eng_start;
  logic                       eng_mode;
  logic                       eng_done;
  logic                       busy;
  logic                       done_pulse;
  logic                       err_pulse;
  logic [1:0]                 err_code;
  modport slave (
    input  instr, instr_valid, dma_ready, dma_done, eng_done,
    output instr_ready, dma_valid, dma_addr, dma_dir, dma_sel, eng_start, eng_mode,
           busy, done_pulse, err_pulse, err_code
  );
  modport master (
    output instr, instr_valid, dma_ready, dma_done, eng_done,
    input  instr_ready, dma_valid, dma_addr, dma_dir, dma_sel, eng_start, eng_mode,
           busy, done_pulse, err_pulse, err_code
  );
endinterface

// File: rtl/aes_cmd_sequencer.sv
// aes_cmd_sequencer: runs one AES job at a time (key fetch, text fetch, engine run, write-back)
module aes_cmd_sequencer #(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst,
  aes_cmd_sequencer_if.slave bus
);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [3:0] {IDLE, KEY_REQ, KEY_WAIT, TXT_REQ, TXT_WAIT, START, RUN, WB_REQ, WB_WAIT} state_t;
  state_t             state_q, state_d;
  logic [ADDRW-1:0]   key_q, key_d, text_q, text_d, dest_q, dest_d, addr_q;
  logic [OPCODEW-1:0] op;
  logic [TW-1:0]      timer_q, timer_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               mode_q, mode_d, key_loaded_q, key_loaded_d, done_q, done_d, err_q, err_d;
  logic               ready_q, busy_q, dv_q, dir_q, sel_q, start_q, acc, expire, wt;
  // next-state, latched fields and completion/error events for the coming edge
  always_comb begin
    op           = bus.instr[3*ADDRW +: OPCODEW];
    acc          = state_q == IDLE && bus.instr_valid;
    key_d        = acc ? bus.instr[2*ADDRW +: ADDRW] : key_q;
    text_d       = acc ? bus.instr[ADDRW +: ADDRW] : text_q;
    dest_d       = acc ? bus.instr[0 +: ADDRW] : dest_q;
    mode_d       = acc ? op[1] : mode_q;
    wt           = state_q inside {KEY_WAIT, TXT_WAIT, RUN};
    expire       = TIMEOUT != 0 && wt && timer_q == TLAST;
    state_d      = state_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    key_loaded_d = key_loaded_q;
    case (state_q)
      IDLE:     if (acc) begin
                  if (!op[0]) state_d = KEY_REQ;
                  else if (key_loaded_q) state_d = TXT_REQ;
                  else begin err_d = 1'b1; err_code_d = 2'b01; end
                end
      KEY_REQ:  if (bus.dma_ready) state_d = KEY_WAIT;
      KEY_WAIT: if (bus.dma_done) begin state_d = TXT_REQ; key_loaded_d = 1'b1; end
                else if (expire) key_loaded_d = 1'b0;
      TXT_REQ:  if (bus.dma_ready) state_d = TXT_WAIT;
      TXT_WAIT: if (bus.dma_done) state_d = START;
      START:    state_d = RUN;
      RUN:      if (bus.eng_done) state_d = WB_REQ;
      WB_REQ:   if (bus.dma_ready) state_d = WB_WAIT;
      WB_WAIT:  if (bus.dma_done) begin state_d = IDLE; done_d = 1'b1; end
      default:  state_d = IDLE;
    endcase
    if (expire && state_d == state_q) begin
      state_d    = IDLE;
      err_d      = 1'b1;
      err_code_d = 2'b10;
    end
    timer_d = (state_d != state_q || !wt) ? '0 : timer_q + TW'(timer_q != TMAX);
  end
  // state, job context and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      key_q        <= '0;
      text_q       <= '0;
      dest_q       <= '0;
      mode_q       <= 1'b0;
      key_loaded_q <= 1'b0;
      timer_q      <= '0;
      err_code_q   <= 2'b00;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      dv_q         <= 1'b0;
      addr_q       <= '0;
      dir_q        <= 1'b0;
      sel_q        <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      text_q       <= text_d;
      dest_q       <= dest_d;
      mode_q       <= mode_d;
      key_loaded_q <= key_loaded_d;
      timer_q      <= timer_d;
      err_code_q   <= err_code_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ready_q      <= state_d == IDLE;
      busy_q       <= state_d != IDLE;
      dv_q         <= state_d inside {KEY_REQ, TXT_REQ, WB_REQ};
      addr_q       <= state_d == KEY_REQ ? key_d : state_d == TXT_REQ ? text_d : state_d == WB_REQ ? dest_d : '0;
      dir_q        <= state_d == WB_REQ;
      sel_q        <= state_d inside {TXT_REQ, WB_REQ};
      start_q      <= state_d == START;
    end
  end
  assign bus.instr_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.dma_valid   = dv_q;
  assign bus.dma_addr    = addr_q;
  assign bus.dma_dir     = dir_q;
  assign bus.dma_sel     = sel_q;
  assign bus.eng_start   = start_q;
  assign bus.eng_mode    = mode_q;
  assign bus.done_pulse  = done_q;
  assign bus.err_pulse   = err_q;
  assign bus.err_code    = err_code_q;
endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// tb_aes_cmd_sequencer: directed checks of job sequencing, key reuse, stalls, timeout and reset abort
module tb_aes_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  aes_cmd_sequencer_if #(.ADDRW(24), .OPCODEW(2)) bus ();
  aes_cmd_sequencer #(.ADDRW(24), .OPCODEW(2), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int cyc, n;
  logic [25:0] cmd [4];
  logic ok;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic job(input logic [1:0] op, input logic [23:0] k, input logic [23:0] t, input logic [23:0] d);
    logic vp, sp;
    vp = 1'b0;
    sp = 1'b0;
    n = 0;
    cyc = 0;
    bus.instr = {op, k, t, d};
    bus.instr_valid = 1'b1;
    bus.dma_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      cyc++;
      bus.instr_valid = 1'b0;
      bus.dma_done = vp;
      bus.eng_done = sp;
      vp = bus.dma_valid;
      sp = bus.eng_start;
      if (bus.dma_valid && n < 4) begin
        cmd[n] = {bus.dma_dir, bus.dma_sel, bus.dma_addr};
        n++;
      end
      if (bus.done_pulse || bus.err_pulse) break;
    end
    bus.dma_done = 1'b0;
    bus.eng_done = 1'b0;
  endtask
  initial begin
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.dma_ready = 1'b0;
    bus.dma_done = 1'b0;
    bus.eng_done = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(bus.instr_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_dv", 32'(bus.dma_valid), 0);
    chk("rst_code", 32'(bus.err_code), 0);
    chk("rst_pulses", 32'({bus.done_pulse, bus.err_pulse, bus.eng_start}), 0);
    rst = 1'b0;
    job(2'b00, 24'h000100, 24'h000200, 24'h000300);
    chk("t1_cyc", 32'(cyc), 9);
    chk("t1_ncmd", 32'(n), 3);
    chk("t1_key", 32'(cmd[0]), 32'h0000100);
    chk("t1_txt", 32'(cmd[1]), 32'h1000200);
    chk("t1_wb", 32'(cmd[2]), 32'h3000300);
    chk("t1_done", 32'(bus.done_pulse), 1);
    chk("t1_err", 32'(bus.err_pulse), 0);
    chk("t1_mode", 32'(bus.eng_mode), 0);
    step();
    chk("t1_done_1cyc", 32'(bus.done_pulse), 0);
    job(2'b01, 24'h0000AA, 24'h000444, 24'h000555);
    chk("t2_cyc", 32'(cyc), 7);
    chk("t2_ncmd", 32'(n), 2);
    chk("t2_first", 32'(cmd[0]), 32'h1000444);
    chk("t2_done", 32'(bus.done_pulse), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    job(2'b01, 24'h000001, 24'h000002, 24'h000003);
    chk("t3_cyc", 32'(cyc), 1);
    chk("t3_err", 32'(bus.err_pulse), 1);
    chk("t3_code", 32'(bus.err_code), 1);
    chk("t3_ncmd", 32'(n), 0);
    chk("t3_ready", 32'(bus.instr_ready), 1);
    bus.instr = {2'b10, 24'h0A0000, 24'h0B0000, 24'h0C0000};
    bus.instr_valid = 1'b1;
    bus.dma_ready = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    chk("t4_key_addr", 32'(bus.dma_addr), 32'h0A0000);
    chk("t4_mode", 32'(bus.eng_mode), 1);
    step();
    bus.dma_ready = 1'b0;
    bus.dma_done = 1'b1;
    step();
    bus.dma_done = 1'b0;
    chk("t4_txt_addr", 32'({bus.dma_valid, bus.dma_addr}), 32'h10B0000);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!(bus.dma_valid && bus.dma_addr == 24'h0B0000 && !bus.err_pulse && bus.busy)) ok = 1'b0;
    end
    chk("t4_stall_stable", 32'(ok), 1);
    bus.dma_ready = 1'b1;
    step();
    chk("t4_wait_dv", 32'(bus.dma_valid), 0);
    bus.dma_done = 1'b1;
    step();
    bus.dma_done = 1'b0;
    chk("t4_start", 32'(bus.eng_start), 1);
    step();
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    chk("t4_wb", 32'({bus.dma_dir, bus.dma_addr}), 32'h10C0000);
    step();
    bus.dma_done = 1'b1;
    step();
    bus.dma_done = 1'b0;
    chk("t4_done", 32'(bus.done_pulse), 1);
    bus.instr = {2'b01, 24'h000000, 24'h0D0000, 24'h0E0000};
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    chk("t5_txt_addr", 32'(bus.dma_addr), 32'h0D0000);
    step();
    bus.dma_done = 1'b1;
    step();
    bus.dma_done = 1'b0;
    step();
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.err_pulse || bus.done_pulse || !bus.busy) ok = 1'b0;
    end
    chk("t5_quiet", 32'(ok), 1);
    step();
    chk("t5_err", 32'(bus.err_pulse), 1);
    chk("t5_code", 32'(bus.err_code), 2);
    chk("t5_idle", 32'({bus.instr_ready, bus.busy, bus.done_pulse}), 32'b100);
    bus.instr = {2'b01, 24'h000000, 24'h0F0000, 24'h0E0000};
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    bus.dma_done = 1'b1;
    step();
    bus.dma_done = 1'b0;
    step();
    step();
    chk("t6_in_run", 32'(bus.busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_idle", 32'({bus.instr_ready, bus.busy, bus.dma_valid, bus.eng_start}), 32'b1000);
    chk("t6_no_pulse", 32'({bus.done_pulse, bus.err_pulse}), 0);
    job(2'b01, 24'h000000, 24'h000123, 24'h000456);
    chk("t6_err", 32'(bus.err_pulse), 1);
    chk("t6_code", 32'(bus.err_code), 1);
    chk("t6_ncmd", 32'(n), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
